axil2sreg_bridge: RTL

AXI4-Lite slave that masters the internal register strobe bus (en/wen/addr/din/dout) used by the AXI2S control register blocks. Turns each AXI-Lite read or write into exactly one single-cycle register access. Sits between the PS general-purpose AXI port and the register slaves; one transaction in flight at a time.

---
 rtl/axil2sreg_bridge_if.sv | 45 ++++
 rtl/axil2sreg_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil2sreg_bridge_if.sv
// AXI4-Lite slave-side bundle for axil2sreg_bridge.
// The register strobe bus stays as plain ports on the bridge.
interface axil2sreg_bridge_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awvalid,
        input  s_wdata, s_wstrb, s_wvalid,
        input  s_bready,
        input  s_araddr, s_arvalid,
        input  s_rready,
        output s_awready, s_wready,
        output s_bresp, s_bvalid,
        output s_arready,
        output s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid,
        output s_wdata, s_wstrb, s_wvalid,
        output s_bready,
        output s_araddr, s_arvalid,
        output s_rready,
        input  s_awready, s_wready,
        input  s_bresp, s_bvalid,
        input  s_arready,
        input  s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil2sreg_bridge.sv
// axil2sreg_bridge: AXI4-Lite slave turning each access into one reg strobe.
// Optional macro AXIL2SREG_DECERR_EN: out-of-window addresses get SLVERR.
module axil2sreg_bridge #(
    parameter int          ADDR_W   = 18,
    parameter logic [31:0] WIN_BASE = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    axil2sreg_bridge_if.slave bus,
    output logic              reg_en,
    output logic              reg_wen,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_din,
    input  logic [31:0]       reg_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WSTB,
        RSTB,
        BRESP,
        RRESP
    } state_e;

    state_e state_q, state_d;

    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              aw_err_q, aw_err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              prio_q, prio_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]       reg_din_q, reg_din_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              in_idle;
    logic              aw_hs;
    logic              w_hs;
    logic              wr_rdy;
    logic              ar_ok;
    logic              ar_req;
    logic              contest;
    logic              grant_w;
    logic              grant_r;
    logic              aw_err;
    logic              ar_err;
    logic              wr_err;
    logic [ADDR_W-1:0] aw_addr_now;
    logic [ADDR_W-1:0] ar_addr_now;

    // Byte address with the word-offset bits dropped
    assign aw_addr_now = {bus.s_awaddr[ADDR_W-1:2], 2'b00};
    assign ar_addr_now = {bus.s_araddr[ADDR_W-1:2], 2'b00};

`ifdef AXIL2SREG_DECERR_EN
    assign aw_err = bus.s_awaddr[31:ADDR_W] != WIN_BASE[31:ADDR_W];
    assign ar_err = bus.s_araddr[31:ADDR_W] != WIN_BASE[31:ADDR_W];
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    // Strobes are full-word; sub-word and window bits may go unused
    logic unused_ok;
    assign unused_ok = ^{bus.s_wstrb,
                         bus.s_awaddr[1:0], bus.s_araddr[1:0],
                         bus.s_awaddr[31:ADDR_W], bus.s_araddr[31:ADDR_W],
                         WIN_BASE};

    // Nothing is accepted while reset is held
    assign in_idle = (state_q == IDLE) && rst_n;

    assign aw_hs  = in_idle && !aw_got_q && bus.s_awvalid;
    assign w_hs   = in_idle && !w_got_q && bus.s_wvalid;
    assign wr_rdy = in_idle && (aw_got_q || aw_hs) && (w_got_q || w_hs);

    // A half-captured write blocks new reads until it completes
    assign ar_ok  = !aw_got_q && !w_got_q;
    assign ar_req = in_idle && ar_ok && bus.s_arvalid;

    // prio_q=1 favours the read when both directions compete
    assign contest = wr_rdy && ar_req;
    assign grant_w = wr_rdy && !(contest && prio_q);
    assign grant_r = ar_req && !grant_w;

    assign wr_err = aw_got_q ? aw_err_q : aw_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant, one strobe cycle, then wait for the response
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_w) begin
                    state_d = WSTB;
                end else if (grant_r) begin
                    state_d = RSTB;
                end
            end
            WSTB:  state_d = BRESP;
            RSTB:  state_d = RRESP;
            BRESP: begin
                if (bus.s_bready) begin
                    state_d = IDLE;
                end
            end
            RRESP: begin
                if (bus.s_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe outputs decoded from state
    always_comb begin
        bus.s_awready = in_idle && !aw_got_q;
        bus.s_wready  = in_idle && !w_got_q;
        bus.s_arready = in_idle && ar_ok && !grant_w;
        bus.s_bvalid  = (state_q == BRESP);
        bus.s_rvalid  = (state_q == RRESP);
        reg_en        = ((state_q == WSTB) || (state_q == RSTB)) && !err_q;
        reg_wen       = (state_q == WSTB) && !err_q;
    end

    // Capture channels, latch the granted access, sample read data
    always_comb begin
        aw_got_d   = aw_got_q;
        w_got_d    = w_got_q;
        awaddr_d   = awaddr_q;
        aw_err_d   = aw_err_q;
        wdata_d    = wdata_q;
        prio_d     = prio_q;
        err_d      = err_q;
        reg_addr_d = reg_addr_q;
        reg_din_d  = reg_din_q;
        rdata_d    = rdata_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;

        if (aw_hs) begin
            aw_got_d = 1'b1;
            awaddr_d = aw_addr_now;
            aw_err_d = aw_err;
        end
        if (w_hs) begin
            w_got_d = 1'b1;
            wdata_d = bus.s_wdata;
        end

        // Round-robin only moves when both sides actually competed
        if (contest) begin
            prio_d = grant_w;
        end

        if (grant_w) begin
            reg_addr_d = aw_got_q ? awaddr_q : aw_addr_now;
            reg_din_d  = w_got_q ? wdata_q : bus.s_wdata;
            err_d      = wr_err;
            bresp_d    = {wr_err, 1'b0};
        end else if (grant_r) begin
            reg_addr_d = ar_addr_now;
            err_d      = ar_err;
            rresp_d    = {ar_err, 1'b0};
        end

        if (state_q == RSTB) begin
            rdata_d = err_q ? 32'h0 : reg_dout;
        end

        if ((state_q == BRESP) && bus.s_bready) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
        end
    end

    // Datapath and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            aw_err_q   <= 1'b0;
            wdata_q    <= 32'h0;
            prio_q     <= 1'b0;
            err_q      <= 1'b0;
            reg_addr_q <= '0;
            reg_din_q  <= 32'h0;
            rdata_q    <= 32'h0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
        end else begin
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awaddr_q   <= awaddr_d;
            aw_err_q   <= aw_err_d;
            wdata_q    <= wdata_d;
            prio_q     <= prio_d;
            err_q      <= err_d;
            reg_addr_q <= reg_addr_d;
            reg_din_q  <= reg_din_d;
            rdata_q    <= rdata_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
        end
    end

    assign reg_addr    = reg_addr_q;
    assign reg_din     = reg_din_q;
    assign bus.s_rdata = rdata_q;
    assign bus.s_bresp = bresp_q;
    assign bus.s_rresp = rresp_q;

endmodule
